// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared types and defaults for the up/down modulo counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Counting direction as carried on the up_dn pin
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Default counter datapath width
    localparam int CNT_WIDTH_DEF = 4;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/count_next_calc.sv
`default_nettype none
// ============================================================================
//  Module      : count_next_calc
//  Description : Combinational next-count and wrap detection for the modulo
//                up/down counter. Priority: load > enable > hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF,
    parameter int MOD   = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap_now
);

    // One extra bit so MOD == 2**WIDTH is representable and the step never
    // depends on natural rollover of the WIDTH-bit register.
    localparam logic [WIDTH:0] c_MOD    = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0] c_MOD_M1 = (WIDTH+1)'(MOD - 1);

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_load_ext;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;
    logic           w_at_top;
    logic           w_at_bottom;
    logic           w_dir_up;

    assign w_q_ext     = {1'b0, q};
    assign w_load_ext  = {1'b0, load_val};
    assign w_inc       = w_q_ext + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec       = w_q_ext - {{WIDTH{1'b0}}, 1'b1};
    assign w_at_top    = (w_q_ext == c_MOD_M1);
    assign w_at_bottom = (w_q_ext == '0);
    assign w_dir_up    = (dir_e'(up_dn) == DIR_UP);

    // Select the next count value: clamped load, wrapped step, or hold
    always_comb begin
        q_next   = q;
        wrap_now = 1'b0;
        if (load) begin
            if (w_load_ext >= c_MOD) begin
                q_next = c_MOD_M1[WIDTH-1:0];
            end else begin
                q_next = load_val;
            end
        end else if (en) begin
            if (w_dir_up) begin
                wrap_now = w_at_top;
                q_next   = w_at_top ? '0 : w_inc[WIDTH-1:0];
            end else begin
                wrap_now = w_at_bottom;
                q_next   = w_at_bottom ? c_MOD_M1[WIDTH-1:0] : w_dec[WIDTH-1:0];
            end
        end
    end

endmodule : count_next_calc
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter
//  Description : Modulo-MOD up/down counter with parallel load, enable,
//                terminal count, registered wrap pulse and sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_sticky
);

    localparam logic [WIDTH:0] c_MOD_M1 = (WIDTH+1)'(MOD - 1);

    // Reject moduli that cannot be counted in WIDTH bits
    if ((MOD < 2) || (MOD > (1 << WIDTH))) begin : g_mod_illegal
        $fatal(1, "updown_mod_counter: MOD=%0d illegal for WIDTH=%0d", MOD, WIDTH);
    end

    logic [WIDTH-1:0] r_q;
    logic             r_wrap_pulse;
    logic             r_ovf_sticky;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_now;

    count_next_calc #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next (
        .q        (r_q),
        .up_dn    (up_dn),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .q_next   (w_q_next),
        .wrap_now (w_wrap_now)
    );

    // Count register, wrap pulse and sticky overflow; wrap beats clr_ovf
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q          <= '0;
            r_wrap_pulse <= 1'b0;
            r_ovf_sticky <= 1'b0;
        end else begin
            r_q          <= w_q_next;
            r_wrap_pulse <= w_wrap_now;
            if (w_wrap_now) begin
                r_ovf_sticky <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf_sticky <= 1'b0;
            end
        end
    end

    assign q          = r_q;
    assign qn         = ~r_q;
    assign wrap_pulse = r_wrap_pulse;
    assign ovf_sticky = r_ovf_sticky;
    assign tc         = ((dir_e'(up_dn) == DIR_UP)   && ({1'b0, r_q} == c_MOD_M1)) ||
                        ((dir_e'(up_dn) == DIR_DOWN) && (r_q == '0));

endmodule : updown_mod_counter
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_mod_counter
//  Description : Self-checking bench for updown_mod_counter. Two instances
//                (MOD=16 and MOD=10) share stimulus and are compared against
//                a modular-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

    localparam int c_W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           up_dn;
    logic           load;
    logic [c_W-1:0] load_val;
    logic           clr_ovf;

    logic [c_W-1:0] q16, qn16, q10, qn10;
    logic           tc16, wp16, ovf16, tc10, wp10, ovf10;

    int n_vec = 0;
    int n_err = 0;

    // Reference state per instance: index 0 -> MOD 16, index 1 -> MOD 10
    int m_mod [2] = '{16, 10};
    int m_q   [2];
    bit m_wp  [2];
    bit m_ovf [2];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(c_W), .MOD(16)) u_dut16 (
        .clk (clk), .reset (reset), .en (en), .up_dn (up_dn), .load (load),
        .load_val (load_val), .clr_ovf (clr_ovf), .q (q16), .qn (qn16),
        .tc (tc16), .wrap_pulse (wp16), .ovf_sticky (ovf16)
    );

    updown_mod_counter #(.WIDTH(c_W), .MOD(10)) u_dut10 (
        .clk (clk), .reset (reset), .en (en), .up_dn (up_dn), .load (load),
        .load_val (load_val), .clr_ovf (clr_ovf), .q (q10), .qn (qn10),
        .tc (tc10), .wrap_pulse (wp10), .ovf_sticky (ovf10)
    );

    // Single comparison point
    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k]   = 0;
            m_wp[k]  = 1'b0;
            m_ovf[k] = 1'b0;
        end
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge
    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            int  mod;
            bit  at_tc;
            bit  wrap;
            mod   = m_mod[k];
            at_tc = up_dn ? (m_q[k] == mod - 1) : (m_q[k] == 0);
            wrap  = !load && en && at_tc;
            if (load)
                m_q[k] = (int'(load_val) >= mod) ? mod - 1 : int'(load_val);
            else if (en)
                m_q[k] = up_dn ? (m_q[k] + 1) % mod : (m_q[k] + mod - 1) % mod;
            m_wp[k]  = wrap;
            m_ovf[k] = wrap ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[k]);
        end
    endfunction

    function automatic bit model_tc(input int k);
        return up_dn ? (m_q[k] == m_mod[k] - 1) : (m_q[k] == 0);
    endfunction

    task automatic check_all();
        check("m16_q",   int'(q16),   m_q[0]);
        check("m16_qn",  int'(qn16),  (~m_q[0]) & 15);
        check("m16_tc",  int'(tc16),  int'(model_tc(0)));
        check("m16_wp",  int'(wp16),  int'(m_wp[0]));
        check("m16_ovf", int'(ovf16), int'(m_ovf[0]));
        check("m10_q",   int'(q10),   m_q[1]);
        check("m10_qn",  int'(qn10),  (~m_q[1]) & 15);
        check("m10_tc",  int'(tc10),  int'(model_tc(1)));
        check("m10_wp",  int'(wp10),  int'(m_wp[1]));
        check("m10_ovf", int'(ovf10), int'(m_ovf[1]));
    endtask

    task automatic step(input bit e, input bit u, input bit l,
                        input logic [c_W-1:0] lv, input bit c);
        en = e; up_dn = u; load = l; load_val = lv; clr_ovf = c;
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0;
        load_val = '0; clr_ovf = 1'b0;
        model_reset();

        // Reset held with enable and up direction active
        #1;
        check_all();
        repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Count up 17 steps from 0: wrap at 15 for MOD16, at 9 for MOD10
        repeat (17) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // Load 9, count up through the wrap, then down from 0
        step(1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Load and enable together with out-of-range value for MOD10
        step(1'b1, 1'b1, 1'b1, 4'd12, 1'b0);
        check("load_clamp_m10", int'(q10), 9);
        check("load_no_wp_m10", int'(wp10), 0);

        // Wrap coincident with clr_ovf keeps the flag; later clr clears it
        step(1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        check("set_wins_m16", int'(ovf16), 1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        check("clr_ovf_m16", int'(ovf16), 0);

        // Asynchronous reset mid-count at q=7
        step(1'b0, 1'b1, 1'b1, 4'd6, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        check("post_reset_q_m16", int'(q16), 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, c_W'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_updown_mod_counter
`default_nettype wire
